// File: rtl/rx_byte_fifo_pkg.sv
// rtl/rx_byte_fifo_pkg.sv - shared UART receive-path constants
//
// Purpose : constants shared between the UART receiver and its byte FIFO.
//           UART_DATA_W must match the receiver's rx_data width.
// Ports   : none (package)
package rx_byte_fifo_pkg;

   localparam int UART_DATA_W    = 8;   // receiver byte width
   localparam int RX_FIFO_ADDR_W = 4;   // default depth = 16 entries
   localparam int RX_DROP_W      = 8;   // dropped-byte counter width

endpackage : rx_byte_fifo_pkg

// File: rtl/rx_fifo_ram.sv
// rtl/rx_fifo_ram.sv - register-array storage for the receive FIFO
//
// Purpose : simple dual-port register array, synchronous write and
//           asynchronous read, so the head byte falls through combinationally.
// Ports   : clk         system clock
//           we          write enable
//           waddr/wdata write address / data
//           raddr       read address
//           rdata       mem[raddr], combinational
module rx_fifo_ram
   import rx_byte_fifo_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int ADDR_W = RX_FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   // Contents are intentionally not reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule : rx_fifo_ram

// File: rtl/rx_byte_fifo.sv
// rtl/rx_byte_fifo.sv - UART receive byte FIFO with overrun tracking
//
// Purpose : captures one byte per rising edge of rx_rdy into a first-word-
//           fall-through FIFO, hands bytes out over valid/ready, and flags
//           and counts bytes dropped while full.
// Ports   : clk, rst            clock, synchronous active-high reset
//           rx_data, rx_rdy     receiver byte and ready strobe
//           dout, dout_valid    head byte and its valid
//           dout_ready          consumer accept
//           count, full, empty  occupancy and derived flags
//           overrun, drop_cnt   sticky drop flag, saturating drop counter
//           ovr_clr             clears overrun and drop_cnt
module rx_byte_fifo
   import rx_byte_fifo_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int ADDR_W = RX_FIFO_ADDR_W,
   parameter int DROP_W = RX_DROP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_rdy,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              overrun,
   output logic [DROP_W-1:0] drop_cnt,
   input  logic              ovr_clr
);

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   logic              rdy_q;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              overrun_q, overrun_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

   logic push_req, pop, push_ok, drop;

   assign full       = (count_q == FULL_CNT);
   assign empty      = (count_q == '0);
   assign dout_valid = ~empty;
   assign count      = count_q;
   assign overrun    = overrun_q;
   assign drop_cnt   = drop_cnt_q;

   always_comb begin
      push_req = rx_rdy & ~rdy_q;
      pop      = dout_valid & dout_ready;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push_ok  = push_req & (~full | pop);
      drop     = push_req & full & ~pop;

      wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;

      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // A drop in the same cycle as ovr_clr wins: the clear is applied first,
      // then the new drop is recorded on top of it.
      overrun_d  = overrun_q;
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         overrun_d = 1'b1;
         if (ovr_clr) begin
            drop_cnt_d = DROP_W'(1);
         end else if (drop_cnt_q != DROP_MAX) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
         end
      end else if (ovr_clr) begin
         overrun_d  = 1'b0;
         drop_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // rdy_q resets high so a strobe already high at release is no edge.
         rdy_q      <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overrun_q  <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         rdy_q      <= rx_rdy;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overrun_q  <= overrun_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   rx_fifo_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (push_ok & ~rst),
      .waddr (wr_ptr_q),
      .wdata (rx_data),
      .raddr (rd_ptr_q),
      .rdata (dout)
   );

endmodule : rx_byte_fifo

// File: tb/tb_rx_byte_fifo.sv
// tb/tb_rx_byte_fifo.sv - self-checking bench for rx_byte_fifo
module tb_rx_byte_fifo;

   logic       clk = 1'b0;
   logic       rst, rx_rdy, dout_ready, ovr_clr;
   logic [7:0] rx_data;
   logic [7:0] dout;
   logic       dout_valid, full, empty, overrun;
   logic [4:0] count;
   logic [7:0] drop_cnt;

   int checks = 0;
   int errors = 0;

   // reference model
   logic [7:0] m_q[$];
   logic       m_rdy_prev;
   logic       m_ovr;
   int         m_drop;

   typedef struct {
      logic       rst;
      logic       rdy;
      logic [7:0] data;
      logic       rdyo;
      logic       clr;
      int         e_count;
      logic       e_valid;
      logic [7:0] e_dout;
      logic       e_ovr;
      int         e_drop;
   } vec_t;

   vec_t tbl[11];

   always #5 clk = ~clk;

   rx_byte_fifo dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_rdy     (rx_rdy),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .overrun    (overrun),
      .drop_cnt   (drop_cnt),
      .ovr_clr    (ovr_clr)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // Model update from the queue-level rules for one clock edge.
   task automatic model_step(input logic r, input logic rdy, input logic [7:0] d,
                             input logic rdyo, input logic clr);
      bit push, popped;
      if (r) begin
         m_q.delete();
         m_rdy_prev = 1'b1;
         m_ovr      = 1'b0;
         m_drop     = 0;
         return;
      end
      push   = rdy && !m_rdy_prev;
      popped = (m_q.size() != 0) && rdyo;
      m_rdy_prev = rdy;
      if (popped) void'(m_q.pop_front());
      if (push) begin
         if (m_q.size() < 16) begin
            m_q.push_back(d);
         end else begin
            m_ovr  = 1'b1;
            m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
            return;
         end
      end
      if (clr) begin
         m_ovr  = 1'b0;
         m_drop = 0;
      end
   endtask

   task automatic model_cmp();
      chk("count", int'(count), m_q.size());
      chk("empty", int'(empty), int'(m_q.size() == 0));
      chk("full", int'(full), int'(m_q.size() == 16));
      chk("dout_valid", int'(dout_valid), int'(m_q.size() != 0));
      chk("overrun", int'(overrun), int'(m_ovr));
      chk("drop_cnt", int'(drop_cnt), m_drop);
      if (m_q.size() != 0) chk("dout", int'(dout), int'(m_q[0]));
   endtask

   task automatic cyc(input logic r, input logic rdy, input logic [7:0] d,
                      input logic rdyo, input logic clr);
      rst = r; rx_rdy = rdy; rx_data = d; dout_ready = rdyo; ovr_clr = clr;
      model_step(r, rdy, d, rdyo, clr);
      @(posedge clk);
      #1;
      model_cmp();
   endtask

   task automatic push_byte(input logic [7:0] b);
      cyc(1'b0, 1'b1, b, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, b, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; rx_rdy = 1'b0; rx_data = '0; dout_ready = 1'b0; ovr_clr = 1'b0;
      m_rdy_prev = 1'b1; m_ovr = 1'b0; m_drop = 0;

      // reset with rx_rdy high, then pushes of A5 / 3C and two pops
      tbl[0]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 0};
      tbl[1]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 0};
      tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 0};
      tbl[3]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0, 0};
      tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0, 0};
      tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0, 0};
      tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0, 0};
      tbl[7]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 2, 1'b1, 8'hA5, 1'b0, 0};
      tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h3C, 1'b0, 0};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 0};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 0};

      for (int i = 0; i < 11; i++) begin
         cyc(tbl[i].rst, tbl[i].rdy, tbl[i].data, tbl[i].rdyo, tbl[i].clr);
         chk("tbl_count", int'(count), tbl[i].e_count);
         chk("tbl_valid", int'(dout_valid), int'(tbl[i].e_valid));
         chk("tbl_empty", int'(empty), int'(!tbl[i].e_valid));
         if (tbl[i].e_valid) chk("tbl_dout", int'(dout), int'(tbl[i].e_dout));
         chk("tbl_overrun", int'(overrun), int'(tbl[i].e_ovr));
         chk("tbl_drop", int'(drop_cnt), tbl[i].e_drop);
      end

      // level-held rx_rdy stores exactly one byte
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("hold_count", int'(count), 1);
      chk("hold_dout", int'(dout), 8'h55);

      // fill to 16, two more pushes are dropped
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      push_byte(8'h10);
      push_byte(8'h11);
      chk("fill_full", int'(full), 1);
      chk("fill_count", int'(count), 16);
      chk("fill_overrun", int'(overrun), 1);
      chk("fill_drop", int'(drop_cnt), 2);
      for (int i = 0; i < 16; i++) begin
         chk("drain_dout", int'(dout), i);
         cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drain_empty", int'(empty), 1);

      // offset pointers, refill across the wrap, push+pop while full
      for (int i = 0; i < 3; i++) push_byte(8'hE0 + 8'(i));
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
      chk("wrap_full", int'(full), 1);
      chk("wrap_head", int'(dout), 8'h20);
      cyc(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("pp_overrun", int'(overrun), 0);
      chk("pp_count", int'(count), 16);
      for (int i = 0; i < 16; i++) begin
         chk("wrap_dout", int'(dout), (i < 15) ? 8'h21 + i : 8'h77);
         cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      end

      // ovr_clr alone, ovr_clr coincident with a drop, saturation
      for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
      push_byte(8'hFF);
      push_byte(8'hFF);
      chk("pre_clr_drop", int'(drop_cnt), 2);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_overrun", int'(overrun), 0);
      chk("clr_drop", int'(drop_cnt), 0);
      push_byte(8'hFF);
      push_byte(8'hFF);
      cyc(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
      chk("clr_drop_overrun", int'(overrun), 1);
      chk("clr_drop_cnt", int'(drop_cnt), 1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) push_byte(8'hAA);
      chk("sat_drop", int'(drop_cnt), 255);
      chk("sat_overrun", int'(overrun), 1);

      // randomized traffic against the queue model
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 499) == 0),
             ($urandom_range(0, 2) != 0),
             8'($urandom),
             ($urandom_range(0, 3) == 0) || (i > 1500 && $urandom_range(0, 1) == 1),
             ($urandom_range(0, 63) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_rx_byte_fifo
